// File: rtl/factorial_core.sv
// Iterative N! engine: one shift-add multiplier bit per cycle, LSB first,
// multiplying a 64-bit running product by a descending 32-bit multiplier.
module factorial_core (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_start,
    input  logic        op_clear,
    input  logic [31:0] operand,
    output logic [63:0] result,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t      st, st_nxt;
    logic [63:0] acc;
    logic [31:0] m;
    logic [95:0] part;
    logic [4:0]  bit_cnt;

    logic [95:0] addend;
    logic [95:0] part_sum;
    logic [31:0] m_dec;
    logic        last_bit;
    logic        mul_fin;

    // Partial-product step; 96 bits holds acc << 31 plus carries without loss.
    always_comb begin
        addend   = m[bit_cnt] ? ({32'b0, acc} << bit_cnt) : 96'b0;
        part_sum = part + addend;
        m_dec    = m - 32'd1;
        last_bit = (bit_cnt == 5'd31);
        mul_fin  = last_bit && (m_dec == 32'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) st <= S_IDLE;
        else          st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE: begin
                if (op_clear)                     st_nxt = S_IDLE;
                else if (op_start && operand < 32'd2) st_nxt = S_DONE;
                else if (op_start)                st_nxt = S_MUL;
            end
            S_MUL: begin
                if (op_clear)     st_nxt = S_IDLE;
                else if (mul_fin) st_nxt = S_DONE;
            end
            S_DONE: begin
                if (op_clear) st_nxt = S_IDLE;
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        state = st;
        busy  = (st == S_MUL);
        done  = (st == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result   <= 64'b0;
            overflow <= 1'b0;
            acc      <= 64'b0;
            m        <= 32'b0;
            part     <= 96'b0;
            bit_cnt  <= 5'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (op_clear) begin
                        result   <= 64'b0;
                        overflow <= 1'b0;
                    end else if (op_start && operand < 32'd2) begin
                        result   <= 64'd1;
                        overflow <= 1'b0;
                    end else if (op_start) begin
                        m        <= operand;
                        acc      <= 64'd1;
                        part     <= 96'b0;
                        bit_cnt  <= 5'b0;
                        overflow <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (op_clear) begin
                        result   <= 64'b0;
                        overflow <= 1'b0;
                        acc      <= 64'b0;
                        m        <= 32'b0;
                        part     <= 96'b0;
                        bit_cnt  <= 5'b0;
                    end else if (last_bit) begin
                        // Keep going on the truncated product once overflow is flagged.
                        acc      <= part_sum[63:0];
                        overflow <= overflow | (|part_sum[95:64]);
                        m        <= m_dec;
                        part     <= 96'b0;
                        bit_cnt  <= 5'b0;
                        if (mul_fin) result <= part_sum[63:0];
                    end else begin
                        part    <= part_sum;
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    if (op_clear) begin
                        result   <= 64'b0;
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
